// File: rtl/fsm_bits_pattern_tx.sv
// fsm_bits_pattern_tx
// Serial bit-pattern transmitter. A PAT_W-bit pattern is sent MSB first,
// one bit per accepted beat (x_valid && x_ready), for a programmed number
// of copies. Optional runs of zero bits separate consecutive copies.
//
// Ports
//   clk      rising-edge clock
//   aresetn  asynchronous active-low reset
//   start    begin a transfer (sampled in IDLE only; ignored when copies==0)
//   pattern  pattern to send, MSB first (latched on accepted start)
//   copies   number of copies (latched on accepted start)
//   gap      zero bits between copies (latched on accepted start)
//   x_out    serial data bit
//   x_valid  x_out carries a bit this cycle
//   x_ready  consumer accepts the bit
//   sof      x_out is the MSB of a copy
//   busy     transfer in progress (SHIFT or GAP)
//   done     one-cycle pulse after the final bit is accepted
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | waiting for start with copies!=0
// SHIFT | presenting pattern bit idx of the current copy
// GAP   | presenting zero bits between two copies
// DONE  | one-cycle completion pulse, start ignored
module fsm_bits_pattern_tx #(
   parameter int PAT_W = 3,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             aresetn,
   input  logic             start,
   input  logic [PAT_W-1:0] pattern,
   input  logic [CNT_W-1:0] copies,
   input  logic [CNT_W-1:0] gap,
   output logic             x_out,
   output logic             x_valid,
   input  logic             x_ready,
   output logic             sof,
   output logic             busy,
   output logic             done
);

   localparam int IW = (PAT_W > 1) ? $clog2(PAT_W) : 1;
   localparam logic [IW-1:0] IDX_MSB = IW'(PAT_W - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      GAP   = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t             state_q,       state_d;
   logic [PAT_W-1:0]   pat_q,         pat_d;
   logic [IW-1:0]      idx_q,         idx_d;
   logic [CNT_W-1:0]   copies_left_q, copies_left_d;
   logic [CNT_W-1:0]   gap_cfg_q,     gap_cfg_d;
   logic [CNT_W-1:0]   gap_left_q,    gap_left_d;

   logic               x_out_q,   x_out_d;
   logic               x_valid_q, x_valid_d;
   logic               sof_q,     sof_d;
   logic               busy_q,    busy_d;
   logic               done_q,    done_d;

   // state and output registers
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         state_q       <= IDLE;
         pat_q         <= '0;
         idx_q         <= '0;
         copies_left_q <= '0;
         gap_cfg_q     <= '0;
         gap_left_q    <= '0;
         x_out_q       <= 1'b0;
         x_valid_q     <= 1'b0;
         sof_q         <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         pat_q         <= pat_d;
         idx_q         <= idx_d;
         copies_left_q <= copies_left_d;
         gap_cfg_q     <= gap_cfg_d;
         gap_left_q    <= gap_left_d;
         x_out_q       <= x_out_d;
         x_valid_q     <= x_valid_d;
         sof_q         <= sof_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
      end
   end

   // next-state logic; in SHIFT and GAP x_valid is always high, so a beat
   // is simply x_ready
   always_comb begin
      state_d       = state_q;
      pat_d         = pat_q;
      idx_d         = idx_q;
      copies_left_d = copies_left_q;
      gap_cfg_d     = gap_cfg_q;
      gap_left_d    = gap_left_q;

      case (state_q)
         IDLE: begin
            if (start && (copies != '0)) begin
               pat_d         = pattern;
               copies_left_d = copies;
               gap_cfg_d     = gap;
               idx_d         = IDX_MSB;
               state_d       = SHIFT;
            end
         end
         SHIFT: begin
            if (x_ready) begin
               if (idx_q != '0) begin
                  idx_d = idx_q - IW'(1);
               end else if (copies_left_q == CNT_W'(1)) begin
                  state_d = DONE;
               end else begin
                  copies_left_d = copies_left_q - CNT_W'(1);
                  if (gap_cfg_q == '0) begin
                     idx_d = IDX_MSB;
                  end else begin
                     gap_left_d = gap_cfg_q;
                     state_d    = GAP;
                  end
               end
            end
         end
         GAP: begin
            if (x_ready) begin
               gap_left_d = gap_left_q - CNT_W'(1);
               if (gap_left_q == CNT_W'(1)) begin
                  idx_d   = IDX_MSB;
                  state_d = SHIFT;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // outputs are registered, so they are decoded from the next state; this
   // gives the one-cycle start-to-first-bit latency and keeps x_out stable
   // while a beat is stalled (next state equals current state then)
   always_comb begin
      x_out_d   = 1'b0;
      x_valid_d = 1'b0;
      sof_d     = 1'b0;
      busy_d    = 1'b0;
      done_d    = 1'b0;

      case (state_d)
         SHIFT: begin
            x_valid_d = 1'b1;
            busy_d    = 1'b1;
            x_out_d   = pat_d[idx_d];
            sof_d     = (idx_d == IDX_MSB);
         end
         GAP: begin
            x_valid_d = 1'b1;
            busy_d    = 1'b1;
         end
         DONE: begin
            done_d = 1'b1;
         end
         default: begin
            x_valid_d = 1'b0;
         end
      endcase
   end

   assign x_out   = x_out_q;
   assign x_valid = x_valid_q;
   assign sof     = sof_q;
   assign busy    = busy_q;
   assign done    = done_q;

endmodule

// File: tb/tb_fsm_bits_pattern_tx.sv
// Bench for fsm_bits_pattern_tx: a queue-based reference model expands each
// accepted transfer into the exact list of bits to emit; a monitor compares
// the DUT outputs with the queue head every cycle. Directed cases pin the
// model with hand-computed traces, then a randomized phase follows.
module tb_fsm_bits_pattern_tx;

   localparam int PAT_W = 3;
   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             aresetn;
   logic             start;
   logic [PAT_W-1:0] pattern;
   logic [CNT_W-1:0] copies;
   logic [CNT_W-1:0] gap;
   logic             x_out;
   logic             x_valid;
   logic             x_ready;
   logic             sof;
   logic             busy;
   logic             done;

   fsm_bits_pattern_tx #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
      .clk     (clk),
      .aresetn (aresetn),
      .start   (start),
      .pattern (pattern),
      .copies  (copies),
      .gap     (gap),
      .x_out   (x_out),
      .x_valid (x_valid),
      .x_ready (x_ready),
      .sof     (sof),
      .busy    (busy),
      .done    (done)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   typedef struct packed { logic b; logic s; } beat_t;
   beat_t q[$];
   logic  done_exp = 1'b0;

   always @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         q.delete();
         done_exp <= 1'b0;
      end else begin
         if (q.size() > 0) begin
            if (x_ready) begin
               void'(q.pop_front());
               done_exp <= (q.size() == 0);
            end else begin
               done_exp <= 1'b0;
            end
         end else begin
            if (!done_exp && start && (copies != '0)) begin
               for (int c = 0; c < int'(copies); c++) begin
                  for (int b = PAT_W - 1; b >= 0; b--)
                     q.push_back('{b: pattern[b], s: (b == PAT_W - 1)});
                  if (c < int'(copies) - 1)
                     for (int g = 0; g < int'(gap); g++)
                        q.push_back('{b: 1'b0, s: 1'b0});
               end
            end
            done_exp <= 1'b0;
         end
      end
   end

   // ---------------- monitor ----------------
   int    n_vec = 0;
   int    n_err = 0;
   int    lit_seq = 0;
   int    lit_seen = 0;
   int    lit_act;
   int    lit_exp;
   string lit_name;

   always @(negedge clk) begin : monitor
      int    v;
      int    e;
      logic  ev, eo, es;
      v  = 1;
      e  = 0;
      ev = (q.size() > 0);
      eo = ev ? q[0].b : 1'b0;
      es = ev ? q[0].s : 1'b0;
      if ({x_valid, x_out, sof, busy, done} !== {ev, eo, es, ev, done_exp}) begin
         e = 1;
         $display("FAIL cycle_cmp t=%0t: got valid=%b out=%b sof=%b busy=%b done=%b, want valid=%b out=%b sof=%b busy=%b done=%b",
                  $time, x_valid, x_out, sof, busy, done, ev, eo, es, ev, done_exp);
      end
      if (lit_seq != lit_seen) begin
         lit_seen = lit_seq;
         v = v + 1;
         if (lit_act != lit_exp) begin
            e = e + 1;
            $display("FAIL %s: got 0x%0h want 0x%0h", lit_name, lit_act, lit_exp);
         end
      end
      n_vec <= n_vec + v;
      n_err <= n_err + e;
   end

   // ---------------- stimulus helpers ----------------
   logic [15:0] tr_vld, tr_out, tr_sof, tr_done, tr_busy;

   // Called and returns at posedge+1.
   task automatic check_lit(input string name, input int act, input int exp);
      lit_name = name;
      lit_act  = act;
      lit_exp  = exp;
      lit_seq  = lit_seq + 1;
      @(negedge clk);
      #1;
      @(posedge clk);
      #1;
   endtask

   // Drive n cycles (cycle 0 = first) and record outputs per cycle.
   task automatic run_seq(input logic [2:0] p0, input logic [3:0] c0, input logic [3:0] g0,
                          input logic [2:0] p1, input logic [3:0] c1, input logic [3:0] g1,
                          input logic [15:0] smask, input logic [15:0] rmask, input int n);
      tr_vld = '0; tr_out = '0; tr_sof = '0; tr_done = '0; tr_busy = '0;
      for (int i = 0; i < n; i++) begin
         start   = smask[i];
         pattern = (i == 0) ? p0 : p1;
         copies  = (i == 0) ? c0 : c1;
         gap     = (i == 0) ? g0 : g1;
         x_ready = rmask[i];
         @(negedge clk);
         tr_vld[i]  = x_valid;
         tr_out[i]  = x_out;
         tr_sof[i]  = sof;
         tr_done[i] = done;
         tr_busy[i] = busy;
         @(posedge clk);
         #1;
      end
      start   = 1'b0;
      x_ready = 1'b1;
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int found;
      logic rv, rb, rs;
      aresetn = 1'b0;
      start   = 1'b0;
      pattern = '0;
      copies  = '0;
      gap     = '0;
      x_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_lit("reset_outputs", int'({x_valid, x_out, sof, busy, done}), 0);
      aresetn = 1'b1;
      @(posedge clk);
      #1;

      // case 1: single copy
      run_seq(3'b101, 4'd1, 4'd0, 3'b101, 4'd1, 4'd0, 16'h0001, 16'hFFFF, 6);
      check_lit("c1_valid", int'(tr_vld[5:0]), 'h0E);
      check_lit("c1_out",   int'(tr_out[5:0]), 'h0A);
      check_lit("c1_sof",   int'(tr_sof[5:0]), 'h02);
      check_lit("c1_done",  int'(tr_done[5:0]), 'h10);
      check_lit("c1_busy",  int'(tr_busy[5:0]), 'h0E);

      // case 2: two copies back to back
      run_seq(3'b101, 4'd2, 4'd0, 3'b101, 4'd2, 4'd0, 16'h0001, 16'hFFFF, 9);
      check_lit("c2_valid", int'(tr_vld[8:0]), 'h07E);
      check_lit("c2_out",   int'(tr_out[8:0]), 'h05A);
      check_lit("c2_sof",   int'(tr_sof[8:0]), 'h012);
      check_lit("c2_done",  int'(tr_done[8:0]), 'h080);

      // case 3: two copies with a 2-bit gap
      run_seq(3'b101, 4'd2, 4'd2, 3'b101, 4'd2, 4'd2, 16'h0001, 16'hFFFF, 11);
      check_lit("c3_valid", int'(tr_vld[10:0]), 'h1FE);
      check_lit("c3_out",   int'(tr_out[10:0]), 'h14A);
      check_lit("c3_sof",   int'(tr_sof[10:0]), 'h042);
      check_lit("c3_done",  int'(tr_done[10:0]), 'h200);

      // case 4: backpressure in cycles 2-4
      run_seq(3'b101, 4'd1, 4'd0, 3'b101, 4'd1, 4'd0, 16'h0001, 16'hFFE3, 9);
      check_lit("c4_valid", int'(tr_vld[8:0]), 'h07E);
      check_lit("c4_out",   int'(tr_out[8:0]), 'h042);
      check_lit("c4_done",  int'(tr_done[8:0]), 'h080);

      // case 5a: copies==0 start is rejected
      run_seq(3'b111, 4'd0, 4'd3, 3'b111, 4'd0, 4'd3, 16'h0001, 16'hFFFF, 12);
      check_lit("c5_zero_valid", int'(tr_vld[11:0]), 0);
      check_lit("c5_zero_done",  int'(tr_done[11:0] | tr_busy[11:0]), 0);

      // case 5b: overlapping start with different pattern is ignored
      run_seq(3'b101, 4'd2, 4'd1, 3'b010, 4'd5, 4'd0, 16'h0009, 16'hFFFF, 11);
      check_lit("c5_ovl_valid", int'(tr_vld[10:0]), 'h0FE);
      check_lit("c5_ovl_out",   int'(tr_out[10:0]), 'h0AA);
      check_lit("c5_ovl_sof",   int'(tr_sof[10:0]), 'h022);
      check_lit("c5_ovl_done",  int'(tr_done[10:0]), 'h100);

      // case 6: reset in cycle 2 of a 3-copy transfer
      run_seq(3'b101, 4'd3, 4'd0, 3'b101, 4'd3, 4'd0, 16'h0001, 16'hFFFF, 2);
      #1;
      aresetn = 1'b0;
      #1;
      rv = x_valid;
      rb = busy;
      rs = sof;
      check_lit("c6_rst_valid", int'(rv), 0);
      check_lit("c6_rst_busy",  int'(rb), 0);
      check_lit("c6_rst_sof",   int'(rs), 0);
      aresetn = 1'b1;
      run_seq(3'b101, 4'd1, 4'd0, 3'b101, 4'd1, 4'd0, 16'h0001, 16'hFFFF, 6);
      check_lit("c6_after_valid", int'(tr_vld[5:0]), 'h0E);
      check_lit("c6_after_out",   int'(tr_out[5:0]), 'h0A);
      check_lit("c6_after_done",  int'(tr_done[5:0]), 'h10);

      // counter maximums: 15 copies, 15-bit gaps -> 255 beats, done in cycle 256
      run_seq(3'b110, 4'd15, 4'd15, 3'b110, 4'd15, 4'd15, 16'h0001, 16'hFFFF, 1);
      found = -1;
      for (int i = 1; i < 400; i++) begin
         @(negedge clk);
         if (done && found < 0) found = i;
         @(posedge clk);
         #1;
         if (found >= 0) break;
      end
      check_lit("max_done_cycle", found, 256);

      // randomized phase, checked by the model every cycle
      for (int k = 0; k < 3000; k++) begin
         start   = ($urandom_range(0, 3) == 0);
         pattern = PAT_W'($urandom);
         copies  = ($urandom_range(0, 9) == 0) ? 4'd15 : CNT_W'($urandom_range(0, 4));
         gap     = ($urandom_range(0, 9) == 0) ? 4'd15 : CNT_W'($urandom_range(0, 3));
         x_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 399) == 0) begin
            #1;
            aresetn = 1'b0;
            #2;
            aresetn = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      start   = 1'b0;
      x_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
